// File: rtl/regfile_pkg.sv
// Shared types and default parameter values for the multi-port register file.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_NREGS      = 32;
    localparam int DEF_NRD        = 2;
    localparam int DEF_NWR        = 2;
    localparam int DEF_INIT_INDEX = 0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_mp_bypass_mux.sv
// One read port's output selection: stored value, optionally forwarded write
// data (REGFILE_BYPASS_EN), and zero forcing for address 0 and during a sweep.
module rf_bypass_mux #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic              idle_i,
    input  logic [AW-1:0]     ra_i,
    input  logic [XLEN-1:0]   stored_i,
    input  logic [NWR-1:0]    we_i,
    input  logic [NWR*AW-1:0] wa_i,
    input  logic [NWR*XLEN-1:0] wd_i,
    output logic [XLEN-1:0]   rd_o
);

    logic [XLEN-1:0] sel;

`ifdef REGFILE_BYPASS_EN
    // Forward the highest-indexed matching write port; later iterations win.
    always_comb begin
        sel = stored_i;
        for (int j = 0; j < NWR; j++) begin
            if (we_i[j] && (wa_i[j*AW +: AW] == ra_i)) begin
                sel = wd_i[j*XLEN +: XLEN];
            end
        end
    end
`else
    logic unused_wr;
    assign sel       = stored_i;
    assign unused_wr = ^{we_i, wa_i, wd_i};
`endif

    // Address 0 and the sweep both read as zero, which also blocks any forwarding there.
    assign rd_o = (idle_i && (ra_i != '0)) ? sel : '0;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardware clear sweep and x0 hardwired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int NREGS      = DEF_NREGS,
    parameter int NRD        = DEF_NRD,
    parameter int NWR        = DEF_NWR,
    parameter int INIT_INDEX = DEF_INIT_INDEX
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_req,
    output logic                   busy,
    input  logic [NWR-1:0]         we,
    input  logic [NWR*$clog2(NREGS)-1:0] wa,
    input  logic [NWR*XLEN-1:0]    wd,
    input  logic [NRD*$clog2(NREGS)-1:0] ra,
    output logic [NRD*XLEN-1:0]    rd
);

    localparam int AW = $clog2(NREGS);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] init_val;
    logic            idle;

    assign idle     = (state_q == RF_IDLE);
    assign busy     = (state_q == RF_CLEAR);
    assign init_val = (INIT_INDEX == 1) ? XLEN'(ptr_q) : '0;

    // Sweep state and pointer; reset forces a fresh sweep from register 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            ptr_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: walk ptr to the last register, then idle until a clear request.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d = RF_IDLE;
                end
            end
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = AW'(1);
                end
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = AW'(1);
            end
        endcase
    end

    // Array update: sweep writes own the array in CLEAR, ports own it in IDLE (highest port wins).
    always_ff @(posedge clk) begin
        rf_q[0] <= '0;
        if (state_q == RF_CLEAR) begin
            rf_q[ptr_q] <= init_val;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] != '0)) begin
                    rf_q[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = ra[i*AW +: AW];

        rf_bypass_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_mux (
            .idle_i   (idle),
            .ra_i     (addr),
            .stored_i (rf_q[addr]),
            .we_i     (we),
            .wa_i     (wa),
            .wd_i     (wd),
            .rd_o     (rd[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: two instances (INIT_INDEX=0 and 1) share stimulus.
module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_req = 1'b0;
    logic [1:0]      we = '0;
    logic [2*AW-1:0] wa = '0;
    logic [63:0]     wd = '0;
    logic [2*AW-1:0] ra = '0;
    logic            busy_a, busy_b;
    logic [63:0]     rd_a, rd_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t sbq[$];

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .INIT_INDEX(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_a),
        .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a)
    );

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .INIT_INDEX(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
        .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b)
    );

    function automatic logic [31:0] rd_of(input int inst, input int port);
        if (inst == 1) return rd_b[port*32 +: 32];
        return rd_a[port*32 +: 32];
    endfunction

    task automatic exp_rd(input int inst, input int port, input logic [31:0] v, input string nm);
        sb_t e;
        e.inst = inst;
        e.port = port;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [31:0] d);
        we[p]            = en;
        wa[p*AW +: AW]   = a;
        wd[p*32 +: 32]   = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    task automatic test_reset;
        sb_t e;
        logic [31:0] obs;
        int cnt;
        set_rd(0, 5'd5);
        set_rd(1, 5'd0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL reset_busy_a: busy=%b want=1", busy_a); end
        total++;
        if (busy_b !== 1'b1) begin bad++; $display("FAIL reset_busy_b: busy=%b want=1", busy_b); end
        exp_rd(1, 0, 32'h0, "reset_rd_zero");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy_a) cnt++;
            else break;
            @(negedge clk);
        end
        total++;
        if (cnt != 31) begin bad++; $display("FAIL sweep_len: busy cycles=%0d want=31", cnt); end
        total++;
        if (busy_b !== 1'b0) begin bad++; $display("FAIL sweep_done_b: busy=%b want=0", busy_b); end
        #1;
        exp_rd(1, 0, 32'd5, "init_index_r5");
        exp_rd(1, 1, 32'd0, "init_index_r0");
        exp_rd(0, 0, 32'd0, "init_zero_r5");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_conflict;
        sb_t e;
        logic [31:0] obs;
        @(negedge clk);
        set_wr(0, 1'b1, 5'd7, 32'hAAAA0000);
        set_wr(1, 1'b1, 5'd7, 32'h5555FFFF);
        set_rd(0, 5'd7);
        #1;
        exp_rd(1, 0, BYP ? 32'h5555FFFF : 32'd7, "conflict_same_cycle_b");
        exp_rd(0, 0, BYP ? 32'h5555FFFF : 32'd0, "conflict_same_cycle_a");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        we = '0;
        #1;
        exp_rd(0, 0, 32'h5555FFFF, "conflict_hi_port_a");
        exp_rd(1, 0, 32'h5555FFFF, "conflict_hi_port_b");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_bypass;
        sb_t e;
        logic [31:0] obs;
        @(negedge clk);
        set_wr(0, 1'b1, 5'd3, 32'h12345678);
        set_wr(1, 1'b0, 5'd0, 32'h0);
        set_rd(0, 5'd3);
        set_rd(1, 5'd7);
        #1;
        exp_rd(1, 0, BYP ? 32'h12345678 : 32'd3, "bypass_same_cycle_b");
        exp_rd(0, 0, BYP ? 32'h12345678 : 32'd0, "bypass_same_cycle_a");
        exp_rd(1, 1, 32'h5555FFFF, "bypass_other_port");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        we = '0;
        #1;
        exp_rd(1, 0, 32'h12345678, "write_visible_next_b");
        exp_rd(0, 0, 32'h12345678, "write_visible_next_a");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_x0;
        sb_t e;
        logic [31:0] obs;
        @(negedge clk);
        set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        set_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        #1;
        exp_rd(0, 0, 32'h0, "x0_same_cycle_a");
        exp_rd(1, 1, 32'h0, "x0_same_cycle_b");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        we = '0;
        #1;
        exp_rd(0, 0, 32'h0, "x0_after_a");
        exp_rd(1, 0, 32'h0, "x0_after_b");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_clear;
        sb_t e;
        logic [31:0] obs;
        int cnt;
        @(negedge clk);
        set_wr(0, 1'b1, 5'd9, 32'hDEADBEEF);
        set_rd(0, 5'd9);
        @(negedge clk);
        we = '0;
        clr_req = 1'b1;
        #1;
        total++;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL clr_busy_before: busy=%b want=0", busy_a); end
        exp_rd(0, 0, 32'hDEADBEEF, "r9_written_a");
        exp_rd(1, 0, 32'hDEADBEEF, "r9_written_b");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
        @(negedge clk);
        clr_req = 1'b0;
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL clr_busy_rise: busy=%b want=1", busy_a); end
        set_wr(0, 1'b1, 5'd3, 32'h11111111);
        set_rd(0, 5'd3);
        set_rd(1, 5'd9);
        #1;
        exp_rd(0, 0, 32'h0, "busy_rd0_a");
        exp_rd(1, 0, 32'h0, "busy_rd0_b");
        exp_rd(1, 1, 32'h0, "busy_rd1_b");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy_a) begin
                cnt++;
                if (cnt == 12) clr_req = 1'b1;
                if (cnt == 13) clr_req = 1'b0;
            end else begin
                break;
            end
            @(negedge clk);
        end
        we = '0;
        clr_req = 1'b0;
        total++;
        if (cnt != 31) begin bad++; $display("FAIL clr_sweep_len: busy cycles=%0d want=31", cnt); end
        set_rd(0, 5'd9);
        set_rd(1, 5'd3);
        #1;
        exp_rd(0, 0, 32'h0, "r9_cleared_a");
        exp_rd(1, 0, 32'd9, "r9_reinit_b");
        exp_rd(0, 1, 32'h0, "r3_drop_a");
        exp_rd(1, 1, 32'd3, "r3_drop_b");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
    endtask

    task automatic test_reset_mid;
        sb_t e;
        logic [31:0] obs;
        int cnt;
        @(negedge clk);
        set_wr(0, 1'b1, 5'd5, 32'hCAFEF00D);
        @(negedge clk);
        we = '0;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int k = 0; k < 11; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL midrst_busy: busy=%b want=1", busy_a); end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy_b !== 1'b1) begin bad++; $display("FAIL midrst_busy_hold: busy=%b want=1", busy_b); end
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy_a) cnt++;
            else break;
            @(negedge clk);
        end
        total++;
        if (cnt != 31) begin bad++; $display("FAIL midrst_sweep_len: busy cycles=%0d want=31", cnt); end
        set_rd(0, 5'd5);
        set_rd(1, 5'd31);
        #1;
        exp_rd(0, 0, 32'h0, "midrst_r5_a");
        exp_rd(1, 0, 32'd5, "midrst_r5_b");
        exp_rd(1, 1, 32'd31, "midrst_r31_b");
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = rd_of(e.inst, e.port);
            total++;
            if (obs !== e.exp) begin bad++; $display("FAIL %s: rd=%h want=%h", e.name, obs, e.exp); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_conflict();
        test_bypass();
        test_x0();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
- REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits.
- REQ-002 The block SHALL have parameter NREGS, default 32, register count; legal values are powers of two, 4 or more.
- REQ-003 The block SHALL have parameter NRD, default 2, number of read ports.
- REQ-004 The block SHALL have parameter NWR, default 2, number of write ports.
- REQ-005 The block SHALL have parameter INIT_INDEX, default 0; 0 sweeps zeros, 1 sweeps each register's own index.
- REQ-006 The block SHALL derive localparam AW = $clog2(NREGS).
- REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-009 The block SHALL have port clr_req, input, 1 bit: request a full register sweep.
- REQ-010 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
- REQ-011 The block SHALL have port we, input, NWR bits: per-write-port enable.
- REQ-012 The block SHALL have port wa, input, NWR*AW bits, packed: write addresses, port j at [j*AW +: AW].
- REQ-013 The block SHALL have port wd, input, NWR*XLEN bits, packed: write data.
- REQ-014 The block SHALL have port ra, input, NRD*AW bits, packed: read addresses.
- REQ-015 The block SHALL have port rd, output, NRD*XLEN bits, packed: read data.

Function
- REQ-016 Writes SHALL occur on the rising clk edge when we[j]=1, state is IDLE and wa[j]!=0.
- REQ-017 Register 0 SHALL never be written and SHALL always read as 0.
- REQ-018 When two or more enabled write ports target the same address in one cycle, the highest-indexed port SHALL win.
- REQ-019 Reads SHALL be combinational, with zero-cycle latency, from the array.
- REQ-020 The FSM SHALL have two states, CLEAR and IDLE, with sweep pointer ptr of width AW.
- REQ-021 In CLEAR, each cycle SHALL write the init value (0, or ptr when INIT_INDEX=1) to rf[ptr], then increment ptr.
- REQ-022 The cycle that writes ptr=NREGS-1 SHALL transition to IDLE; a sweep therefore lasts NREGS-1 cycles.
- REQ-023 In IDLE with clr_req=1, the FSM SHALL go to CLEAR with ptr=1 on the next edge.
- REQ-024 clr_req asserted during CLEAR SHALL be ignored: no restart, no queuing.
- REQ-025 During CLEAR, all port writes SHALL be dropped and all rd outputs SHALL read 0.
- REQ-026 busy SHALL be 1 exactly when the state is CLEAR.

Reset
- REQ-027 While rst_n=0, the block SHALL force state=CLEAR, ptr=1 and busy=1 asynchronously.
- REQ-028 Array contents SHALL NOT be reset directly; they are defined only after the sweep completes.
- REQ-029 After rst_n deasserts, the sweep SHALL start on the first rising edge.
- REQ-030 Reset asserted mid-sweep SHALL restart the sweep from ptr=1.

Configuration
- REQ-031 With macro REGFILE_BYPASS_EN defined, a read with ra[i]!=0 that matches an enabled IDLE write address SHALL return that port's wd in the same cycle; if several ports match, the highest-indexed port's data is returned.
- REQ-032 Without REGFILE_BYPASS_EN, reads SHALL return the stored value only, so a written value is visible from the cycle after the write edge.
- REQ-033 Bypass SHALL never apply to address 0 or during CLEAR.

Structure
- REQ-034 Package regfile_pkg SHALL hold typedef enum rf_state_e {RF_CLEAR, RF_IDLE} and the default parameter constants.
- REQ-035 Sub-module rf_bypass_mux SHALL implement one read port's forwarding selection and SHALL be instantiated NRD times via generate.

Verification
- REQ-036 Reset and sweep, INIT_INDEX=1, NREGS=32: release rst_n -> busy=1 for 31 cycles; then ra=5 -> rd=5 and ra=0 -> rd=0.
- REQ-037 Write conflict: we=2'b11, wa0=wa1=7, wd0=0xAAAA0000, wd1=0x5555FFFF -> next cycle ra=7 reads 0x5555FFFF.
- REQ-038 Bypass with the macro: we0=1, wa0=3, wd0=0x12345678, ra0=3 in the same cycle -> rd0=0x12345678; without the macro, rd0 holds the old value and shows 0x12345678 the next cycle.
- REQ-039 x0 protection: we0=1, wa0=0, wd0=0xFFFFFFFF -> ra=0 reads 0, also with the macro enabled.
- REQ-040 clr_req after writing r9=0xDEADBEEF, INIT_INDEX=0: busy rises the next cycle; writes and reads during busy are dropped and read 0; clr_req pulsed again mid-sweep does not extend it; after 31 cycles r9 reads 0.
- REQ-041 Reset mid-sweep: assert rst_n=0 at ptr=12 -> busy stays 1; after release, the sweep restarts and lasts a full 31 cycles.
